// File: rtl/uart_prog_loader.sv
// uart_prog_loader: packs UART bytes little-endian into 32-bit words and writes them to imem.
// Holds the CPU until CELL_NUMBERS words are stored; LOADER_CHECKSUM_EN adds a trailing XOR byte check.
module uart_prog_loader #(
    parameter int CELL_NUMBERS   = 64,
    parameter int ADDR_W         = 8,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              cpu_hold,
    output logic              load_done,
    output logic              load_error,
    output logic [ADDR_W:0]   words_loaded
);

    localparam bit TO_EN = (TIMEOUT_CYCLES > 0);
    localparam int TW    = TO_EN ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    localparam logic [TW-1:0]   TLIM = TW'(TIMEOUT_CYCLES);
    localparam logic [TW-1:0]   TONE = TW'(1);
    localparam logic [ADDR_W:0] LAST = (ADDR_W + 1)'(CELL_NUMBERS - 1);
    localparam logic [ADDR_W:0] CONE = (ADDR_W + 1)'(1);

    typedef enum logic [2:0] {
        S_LOAD  = 3'd0,
        S_WRITE = 3'd1,
        S_DONE  = 3'd2
`ifdef LOADER_CHECKSUM_EN
        ,
        S_CHECK = 3'd3,
        S_ERROR = 3'd4
`endif
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [1:0]        r_byte_idx;
    logic [ADDR_W:0]   r_word_cnt;
    logic [31:0]       r_shift;
    logic [TW-1:0]     r_idle;

    logic              w_last;
    logic              w_expire;
    logic              w_accept;
    logic [1:0]        w_idx;
    logic              w_word_full;
    logic [31:0]       w_shift_nxt;

`ifdef LOADER_CHECKSUM_EN
    logic [7:0]        r_csum;
    logic [7:0]        w_fold;

    assign w_fold = r_shift[7:0] ^ r_shift[15:8]
                  ^ r_shift[23:16] ^ r_shift[31:24];
`endif

    assign w_last   = (r_word_cnt == LAST);
    assign w_expire = TO_EN && (r_state == S_LOAD)
                   && (r_byte_idx != 2'd0) && (r_idle == TLIM);

    // A byte arriving during a non-final write starts the next word.
    assign w_accept = rx_valid && ((r_state == S_LOAD)
                   || ((r_state == S_WRITE) && !w_last));

    // On expiry the partial word is dropped, so a same-cycle byte is byte 0.
    assign w_idx       = w_expire ? 2'd0 : r_byte_idx;
    assign w_word_full = w_accept && (w_idx == 2'd3);

    always_comb begin
        w_shift_nxt = w_expire ? 32'd0 : r_shift;
        if (w_accept) begin
            w_shift_nxt[{w_idx, 3'b000} +: 8] = rx_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_LOAD;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_LOAD: begin
                if (w_word_full) begin
                    w_state_nxt = S_WRITE;
                end
            end
            S_WRITE: begin
                if (w_last) begin
`ifdef LOADER_CHECKSUM_EN
                    w_state_nxt = S_CHECK;
`else
                    w_state_nxt = S_DONE;
`endif
                end else begin
                    w_state_nxt = S_LOAD;
                end
            end
`ifdef LOADER_CHECKSUM_EN
            S_CHECK: begin
                if (rx_valid) begin
                    w_state_nxt = (rx_data == r_csum) ? S_DONE : S_ERROR;
                end
            end
`endif
            default: begin
                w_state_nxt = r_state;
            end
        endcase
    end

    always_comb begin
        imem_we    = 1'b0;
        imem_addr  = '0;
        imem_wdata = 32'd0;
        cpu_hold   = 1'b1;
        load_done  = 1'b0;
        load_error = 1'b0;
        unique case (r_state)
            S_WRITE: begin
                imem_we    = 1'b1;
                imem_addr  = r_word_cnt[ADDR_W-1:0];
                imem_wdata = r_shift;
            end
            S_DONE: begin
                cpu_hold  = 1'b0;
                load_done = 1'b1;
            end
`ifdef LOADER_CHECKSUM_EN
            S_ERROR: begin
                load_error = 1'b1;
            end
`endif
            default: begin
                imem_we = 1'b0;
            end
        endcase
    end

    assign words_loaded = r_word_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_byte_idx <= 2'd0;
            r_word_cnt <= '0;
            r_shift    <= 32'd0;
            r_idle     <= '0;
        end else begin
            r_shift <= w_shift_nxt;
            if (w_accept) begin
                r_byte_idx <= w_idx + 2'd1;
            end else if (w_expire) begin
                r_byte_idx <= 2'd0;
            end
            if (!TO_EN || rx_valid || w_expire) begin
                r_idle <= '0;
            end else if ((r_state == S_LOAD) && (r_byte_idx != 2'd0)) begin
                r_idle <= r_idle + TONE;
            end
            if (r_state == S_WRITE) begin
                r_word_cnt <= r_word_cnt + CONE;
            end
        end
    end

`ifdef LOADER_CHECKSUM_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_csum <= 8'd0;
        end else if (r_state == S_WRITE) begin
            r_csum <= r_csum ^ w_fold;
        end
    end
`endif

endmodule

// File: doc/uart_prog_loader.md
Name: uart_prog_loader

Overview:
- Sits between the UART receiver and instruction memory inside the CPU/UART top level.
- Packs received bytes little-endian into 32-bit instruction words and writes them to consecutive instruction-memory cells.
- Holds the CPU in reset until CELL_NUMBERS words have been stored, then releases it so execution starts at address 0.

Parameters:
- CELL_NUMBERS, 64: number of 32-bit words in one program image.
- ADDR_W, 8: instruction-memory word-address width; must satisfy 2^ADDR_W >= CELL_NUMBERS.
- TIMEOUT_CYCLES, 100000: idle cycles after which a partially assembled word is discarded; 0 disables the timeout.

Ports:
- clk  input  1  system clock; the only clock in the block.
- rst  input  1  asynchronous, active-low reset.
- rx_valid  input  1  one-cycle strobe: rx_data holds a received byte.
- rx_data  input  8  received byte.
- imem_we  output  1  instruction-memory write enable, one-cycle pulse.
- imem_addr  output  ADDR_W  word address of the write.
- imem_wdata  output  32  assembled instruction word.
- cpu_hold  output  1  1 = CPU held in reset / not fetching.
- load_done  output  1  program image fully loaded.
- load_error  output  1  checksum mismatch; only meaningful with the optional feature.
- words_loaded  output  ADDR_W+1  count of words written so far.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=LOAD, byte_idx=0, word_cnt=0, shift register=0, idle counter=0.
  - imem_we=0, imem_addr=0, imem_wdata=0, cpu_hold=1, load_done=0, load_error=0, words_loaded=0.
- States: LOAD, WRITE, CHECK (feature only), DONE, ERROR (feature only).
- LOAD:
  - On rx_valid, byte k (k = byte_idx, 0..3) goes to wdata[8k+7:8k]; byte_idx increments.
  - When the 4th byte arrives, byte_idx wraps to 0 and the next state is WRITE.
- WRITE (exactly one cycle):
  - imem_we=1, imem_addr=word_cnt, imem_wdata=assembled word.
  - word_cnt and words_loaded increment at the end of this cycle.
  - Latency: imem_we rises the cycle after the rx_valid carrying byte 3.
  - If word_cnt was CELL_NUMBERS-1, go to DONE (or CHECK with the feature); otherwise go back to LOAD.
  - An rx_valid during WRITE is accepted as byte 0 of the next word. Not dropped.
- DONE:
  - load_done=1, cpu_hold=0 from the cycle after the final WRITE.
  - Sticky until reset; all further rx_valid strobes are ignored and no more writes occur.
- Timeout (LOAD only, TIMEOUT_CYCLES>0):
  - The idle counter runs while byte_idx!=0 and clears on every rx_valid.
  - When it reaches TIMEOUT_CYCLES: byte_idx=0, partial data is discarded, word_cnt is unchanged, no write occurs.
  - If rx_valid arrives in the same cycle as expiry, the timeout wins and that byte becomes byte 0 of a fresh word.
- Reset mid-load: everything returns to reset values and loading restarts at address 0; cpu_hold stays 1 throughout.
- word_cnt never exceeds CELL_NUMBERS, so there is no address wrap.

Optional Feature:
- Macro: LOADER_CHECKSUM_EN.
- Defined:
  - A running XOR of every program byte is kept.
  - After the final WRITE the block enters CHECK and waits for one more byte.
  - Byte equal to the running XOR → DONE.
  - Byte not equal → ERROR: load_error=1, cpu_hold=1, load_done=0, sticky until reset; rx ignored.
  - Timeout does not apply in CHECK.
- Undefined: no CHECK or ERROR state, no XOR logic, load_error tied to 0; DONE follows the final WRITE directly.

Test Plan:
- CELL_NUMBERS=2, bytes 93 00 40 00 → single imem_we pulse at addr 0, data 0x00400093, one cycle after the 4th byte; cpu_hold=1.
- Then bytes 13 01 10 00 → write to addr 1, data 0x00100113; load_done=1, cpu_hold=0 the next cycle; words_loaded=2; a further byte 0xFF produces no write.
- TIMEOUT_CYCLES=10: bytes AA BB, 10 idle cycles, then 13 00 00 00 → one write, addr 0, data 0x00000013; words_loaded=1.
- rst pulsed low after 5 bytes → all outputs return to reset values; the next 4 bytes write to addr 0.
- LOADER_CHECKSUM_EN, image from the first two scenarios followed by 0xD1 → load_done=1, load_error=0.
- LOADER_CHECKSUM_EN, same image followed by 0xD0 → load_error=1, cpu_hold=1, load_done=0; further bytes ignored until reset.
